spi_ram_ctrl: RTL and testbench

Command-decoding single-port RAM that sits directly downstream of the SPI slave. It consumes the slave's 10-bit parallel words (`rx_data`/`rx_valid`), interprets the top two bits as an opcode, and writes or reads an internal memory. Read results return to the slave as an 8-bit byte with a one-cycle `tx_valid` strobe, which the slave shifts out on MISO.

---
 rtl/spi_ram_pkg.sv | 25 ++
 rtl/spi_ram_ctrl_if.sv | 27 ++
 rtl/spi_ram_sp.sv | 35 +++
 rtl/spi_ram_ctrl.sv | 118 +++++++++++
 tb/tb_spi_ram_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/spi_ram_pkg.sv
// Shared opcodes, FSM encoding and word widths for the SPI command RAM.
package spi_ram_pkg;

    localparam int unsigned CMD_W  = 10;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        OP_WR_ADDR = 2'b00,
        OP_WR_DATA = 2'b01,
        OP_RD_ADDR = 2'b10,
        OP_RD_DATA = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RD_MEM = 2'b01,
        ST_TX_OUT = 2'b10
    } state_e;

    // Opcode lives in the top two bits of every command word.
    function automatic op_e cmd_op(input logic [CMD_W-1:0] cmd);
        return op_e'(cmd[CMD_W-1:CMD_W-2]);
    endfunction

endpackage

// File: rtl/spi_ram_ctrl_if.sv
// Parallel link between the SPI slave (master modport) and the command RAM (slave modport).
interface spi_ram_ctrl_if;
    import spi_ram_pkg::*;

    logic [CMD_W-1:0]  din;
    logic              rx_valid;
    logic [DATA_W-1:0] dout;
    logic              tx_valid;
    logic              ovr;

    modport master (
        output din,
        output rx_valid,
        input  dout,
        input  tx_valid,
        input  ovr
    );

    modport slave (
        input  din,
        input  rx_valid,
        output dout,
        output tx_valid,
        output ovr
    );

endinterface

// File: rtl/spi_ram_sp.sv
// Synchronous single-port byte array with a registered read port.
module spi_ram_sp
    import spi_ram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic [DATA_W-1:0]    rdata
);

    logic [DATA_W-1:0] mem_q [MEM_DEPTH];

    // Array contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    // Read register doubles as the output byte, so it resets to zero and holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem_q[addr];
        end
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Command decoder and read/write controller for the SPI-attached RAM.
// Optional feature: define SPI_RAM_AUTO_INC_EN to post-increment wr_addr after each
// accepted WR_DATA and rd_addr after each completed read (both wrap).
module spi_ram_ctrl
    import spi_ram_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic         clk,
    input  logic         rst,
    spi_ram_ctrl_if.slave bus
);

    state_e               state_q, state_d;
    logic                 rx_valid_q;
    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic                 ovr_q, ovr_d;

    logic                 rx_rise;
    logic                 accept;
    op_e                  op;
    logic [ADDR_SIZE-1:0] payload;
    logic                 mem_we;
    logic                 mem_re;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [DATA_W-1:0]    mem_rdata;

    // One command per rising edge of rx_valid, and only while idle.
    assign rx_rise = bus.rx_valid && !rx_valid_q;
    assign accept  = rx_rise && (state_q == ST_IDLE);
    assign op      = cmd_op(bus.din);
    assign payload = ADDR_SIZE'(bus.din[DATA_W-1:0]);

    // Next-state, address updates, memory strobes and overrun detection.
    always_comb begin
        state_d   = state_q;
        wr_addr_d = wr_addr_q;
        rd_addr_d = rd_addr_q;
        ovr_d     = ovr_q;
        mem_we    = 1'b0;
        mem_re    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (op)
                        OP_WR_ADDR: wr_addr_d = payload;
                        OP_WR_DATA: begin
                            mem_we = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
                            wr_addr_d = wr_addr_q + 1'b1;
`endif
                        end
                        OP_RD_ADDR: rd_addr_d = payload;
                        OP_RD_DATA: state_d = ST_RD_MEM;
                    endcase
                end
            end
            ST_RD_MEM: begin
                mem_re  = 1'b1;
                state_d = ST_TX_OUT;
            end
            ST_TX_OUT: begin
                state_d = ST_IDLE;
`ifdef SPI_RAM_AUTO_INC_EN
                rd_addr_d = rd_addr_q + 1'b1;
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        // Edges arriving mid-read are dropped but remembered until reset.
        if (rx_rise && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rx_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            rd_addr_q  <= '0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rx_valid_q <= bus.rx_valid;
            wr_addr_q  <= wr_addr_d;
            rd_addr_q  <= rd_addr_d;
            ovr_q      <= ovr_d;
        end
    end

    // Writes only occur in IDLE and reads only in RD_MEM, so one shared address suffices.
    assign mem_addr = mem_we ? wr_addr_q : rd_addr_q;

    spi_ram_sp #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_mem (
        .clk   (clk),
        .rst   (rst),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (bus.din[DATA_W-1:0]),
        .rdata (mem_rdata)
    );

    // Decoded from the state register so reset drops the strobe immediately.
    assign bus.tx_valid = (state_q == ST_TX_OUT);
    assign bus.dout     = mem_rdata;
    assign bus.ovr      = ovr_q;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Scoreboard bench for spi_ram_ctrl: reads push expected bytes and strobe cycles,
// a negedge monitor pops them whenever tx_valid is seen.
module tb_spi_ram_ctrl;
    import spi_ram_pkg::*;

    typedef struct {
        logic [7:0]  data;
        int unsigned cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    int          n_exp  = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;

    spi_ram_ctrl_if bus ();

    spi_ram_ctrl #(
        .MEM_DEPTH (256),
        .ADDR_SIZE (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
        end
    endtask

    // Strobe is expected in the TX_OUT cycle, two edges after the accept edge.
    task automatic push(input logic [7:0] data, input string nm);
        exp_q.push_back('{data: data, cyc: cyc + 2, name: nm});
        n_exp++;
    endtask

    always @(negedge clk) begin
        if (!rst && bus.tx_valid === 1'b1) begin
            pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_tx: dout 0x%02h with no read outstanding", bus.dout);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, "_data"}, bus.dout, mon_e.data);
                check({mon_e.name, "_cycle"}, cyc, mon_e.cyc);
            end
        end
    end

    task automatic send(input logic [9:0] w);
        @(negedge clk);
        bus.din      = w;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
    endtask

    task automatic rd_data(input logic [7:0] exp, input string nm);
        @(negedge clk);
        bus.din      = 10'h300;
        bus.rx_valid = 1'b1;
        push(exp, nm);
        @(negedge clk);
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string nm);
        send({2'b10, a});
        rd_data(exp, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        bus.din      = '0;
        bus.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_dout", bus.dout, 8'h00);
        check("reset_tx_valid", bus.tx_valid, 1'b0);
        check("reset_ovr", bus.ovr, 1'b0);
        rst = 1'b0;

        // Round trip: 0x012, 0x1A5, 0x212, 0x300.
        send(10'h012);
        send(10'h1A5);
        rd(8'h12, 8'hA5, "round_trip");
        repeat (2) @(negedge clk);
        check("dout_hold", bus.dout, 8'hA5);
        check("ovr_quiet", bus.ovr, 1'b0);

        // Level hold: five cycles high; din changes after the first so extra writes show up.
        send(10'h040);
        @(negedge clk);
        bus.din      = 10'h1A5;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.din = 10'h1B6;
        repeat (4) @(negedge clk);
        bus.rx_valid = 1'b0;
        rd(8'h40, 8'hA5, "level_hold_once");
        send(10'h177);
`ifdef SPI_RAM_AUTO_INC_EN
        rd(8'h41, 8'h77, "level_hold_wr_addr");
`else
        rd(8'h40, 8'h77, "level_hold_wr_addr");
`endif

        // Address wrap.
        send(10'h0FF);
        send(10'h111);
        send(10'h122);
`ifdef SPI_RAM_AUTO_INC_EN
        rd(8'hFF, 8'h11, "wrap_ff");
        rd(8'h00, 8'h22, "wrap_00");
`else
        rd(8'hFF, 8'h22, "wrap_ff");
`endif

        // Busy drop: rx_valid is still high entering RD_MEM, so the new edge lands in TX_OUT.
        send(10'h050);
        send(10'h133);
        send(10'h250);
        @(negedge clk);
        bus.din      = 10'h300;
        bus.rx_valid = 1'b1;
        push(8'h33, "busy_read");
        @(negedge clk);
        bus.rx_valid = 1'b0;
        bus.din      = 10'h1CC;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        @(negedge clk);
        check("busy_ovr", bus.ovr, 1'b1);
        rd(8'h50, 8'h33, "busy_no_write");
`ifdef SPI_RAM_AUTO_INC_EN
        send(10'h1DD);
        rd(8'h51, 8'hDD, "busy_wr_addr");
`endif

        // Asynchronous reset mid-cycle, with dout and ovr both non-zero.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_dout", bus.dout, 8'h00);
        check("async_rst_tx_valid", bus.tx_valid, 1'b0);
        check("async_rst_ovr", bus.ovr, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Reset while in RD_MEM: no strobe afterwards, and rd_addr returns to 0.
        send(10'h000);
        send(10'h15A);
        send(10'h212);
        @(negedge clk);
        bus.din      = 10'h300;
        bus.rx_valid = 1'b1;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        rst          = 1'b1;
        #1;
        check("abort_tx_valid", bus.tx_valid, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        rd_data(8'h5A, "post_reset_addr0");

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        check("tx_pulse_count", pulses, n_exp);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
